key_matrix_scan: RTL and testbench
==================================

Name: key_matrix_scan

Overview:
- Scans a 4x4 active-low key matrix. One row is driven at a time; the column lines are sampled for that row.
- Whole-matrix snapshots are debounced over consecutive scan frames.
- Each new single-key press is reported as a 4-bit hex code plus a one-cycle valid strobe.
- It is the input-side counterpart of the scanned seven-segment display path: it drives scan lines out and reads the return lines back. Its outputs feed time-setting and entry logic in the clock design.

Parameters:
- SCAN_DIV, 50000, clk cycles each row is driven per scan slot (0.5 ms at 100 MHz); must be >= 2.
- DEBOUNCE_CNT, 5, consecutive identical frames required before a pattern is accepted; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ROW  out  4  row drive, active-low, one-hot-zero; row r is driven low when ROW[r]=0.
- COL  in  4  column sense, active-low (board pull-ups); COL[c]=0 means a key is closed at (driven row, c).
- key_code  out  4  code of the last reported key, = {row[1:0], col[1:0]}.
- key_valid  out  1  one-cycle strobe; key_code is new on this cycle.
- key_down  out  1  high while the reported key is held (FSM in HELD).

Behaviour:
- Reset values (applied on any clk edge with RST=1, including mid-scan; the next cycle restarts at row 0):
  - ROW=4'b1110, key_code=0, key_valid=0, key_down=0.
  - Slot counter, row index, frame buffer, last_frame and stable count all 0.
  - Debounced pattern = 16'h0; FSM = IDLE.
- Row scan:
  - Slot counter runs 0..SCAN_DIV-1.
  - On the cycle where slot = SCAN_DIV-1:
    - ~COL is captured into frame bits [4r+3:4r] for the current row r.
    - The row index advances r -> r+1 mod 4, and ROW updates on the same edge.
  - COL is never sampled earlier than SCAN_DIV-1 cycles after a row change; this gives settle time.
  - Frame length = 4*SCAN_DIV cycles.
- Frame end (the capture edge for row 3), evaluated on the complete 16-bit frame F:
  - If F == last_frame: stable count increments, saturating at DEBOUNCE_CNT.
  - If F != last_frame: stable count = 1.
  - last_frame <= F in both cases.
  - When the new stable count equals DEBOUNCE_CNT, the debounced pattern <= F. It is assigned once per stable run; a saturated count does not reassign.
  - Any differing frame restarts acceptance.
- Event FSM, updated the cycle after the debounced pattern changes:
  - IDLE:
    - Debounced has exactly one bit set at index k: key_code <= k, key_valid=1 for one cycle, go to HELD.
    - Debounced has >= 2 bits set: go to LOCK, no event.
    - Debounced = 0: stay in IDLE.
  - HELD:
    - Debounced = 0: go to IDLE.
    - Any other change (extra key, different key): stay in HELD, no event. Held keys never auto-repeat.
  - LOCK:
    - Debounced = 0: go to IDLE. Leaving a multi-press requires a full release.
    - Otherwise stay in LOCK, no event.
  - key_down = (state == HELD). key_code holds its value until the next event.
- Latency, press to strobe:
  - Contact changes stable before the affected row's sample point are seen in that frame.
  - key_valid is asserted 1 clk after the frame-end edge of the DEBOUNCE_CNT-th identical frame.
- Width rules:
  - Slot counter width = clog2(SCAN_DIV).
  - Stable count width = clog2(DEBOUNCE_CNT+1).
  - No overflow is possible.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, frame = 16 clk):
- Reset then idle, COL=4'hF:
  - ROW sequences 1110, 1101, 1011, 0111, changing every 4 clk.
  - key_valid never asserts; key_down=0.
- Key (row 2, col 1) closed stably from before frame 0:
  - Exactly one key_valid pulse, 1 clk after the end of frame 2, with key_code=4'h9; key_down=1.
  - No further pulses while the key is held; release for 3 frames -> key_down=0.
- Bounce: key (0,3) closed for one frame, open for one frame, then closed stably:
  - Strobe arrives only after 3 consecutive closed frames, with key_code=4'h3.
  - Exactly one pulse in total.
- Two keys, (1,0) and (3,3), pressed together stably:
  - No strobe; FSM in LOCK.
  - Release (3,3) only: still no strobe.
  - Release all, then press (1,0): one strobe with key_code=4'h4.
- Held (1,1), then (2,2) added and (1,1) released without an all-clear: no new strobe; key_code stays 4'h5.
- RST pulsed mid-row-2 while a key is held:
  - Next cycle ROW=1110, outputs 0.
  - The key is re-reported with key_code unchanged 1 clk after the end of frame 2 counted from reset.

Source files
------------

// File: rtl/key_matrix_scan.sv
// 4x4 active-low key matrix scanner: drives one row at a time, assembles whole-matrix
// frames, debounces them over consecutive frames and reports single-key presses.
module key_matrix_scan #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 5
) (
   input  logic       clk,
   input  logic       RST,
   output logic [3:0] ROW,
   input  logic [3:0] COL,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CNT);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HELD = 2'd1;
   localparam logic [1:0] LOCK = 2'd2;

   logic [SW-1:0] slot_cnt;
   logic [1:0]    row_idx;
   logic [15:0]   frame_buf;
   logic [15:0]   last_frame;
   logic [CW-1:0] stable_cnt;
   logic [15:0]   debounced;
   logic [1:0]    state;

   logic          slot_end;
   logic          frame_end;
   logic [15:0]   full_frame;
   logic          same_frame;
   logic          saturated;
   logic [CW-1:0] next_cnt;
   logic          accept;
   logic          one_hot;
   logic [3:0]    key_idx;

   assign ROW        = ~(4'b0001 << row_idx);
   assign slot_end   = (slot_cnt == SLOT_LAST);
   assign frame_end  = slot_end && (row_idx == 2'd3);
   assign full_frame = {~COL, frame_buf[11:0]};
   assign same_frame = (full_frame == last_frame);
   assign saturated  = (stable_cnt == CNT_MAX);
   assign key_down   = (state == HELD);

   // A saturated run keeps its count and must not re-accept the pattern.
   always_comb begin
      next_cnt = CW'(1);
      if (same_frame) begin
         next_cnt = saturated ? stable_cnt : stable_cnt + CW'(1);
      end
      accept = (next_cnt == CNT_MAX) && !(same_frame && saturated);
   end

   always_comb begin
      one_hot = (debounced != 16'd0) && ((debounced & (debounced - 16'd1)) == 16'd0);
      key_idx = 4'd0;
      for (int k = 0; k < 16; k++) begin
         if (debounced[k]) key_idx = 4'(k);
      end
   end

   // Row scan: columns are sampled at the last cycle of each slot, giving settle time.
   always_ff @(posedge clk) begin
      if (RST) begin
         slot_cnt  <= '0;
         row_idx   <= 2'd0;
         frame_buf <= 16'd0;
      end else begin
         if (slot_end) begin
            slot_cnt                  <= '0;
            row_idx                   <= row_idx + 2'd1;
            frame_buf[4*row_idx +: 4] <= ~COL;
         end else begin
            slot_cnt <= slot_cnt + SW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         last_frame <= 16'd0;
         stable_cnt <= '0;
         debounced  <= 16'd0;
      end else if (frame_end) begin
         last_frame <= full_frame;
         stable_cnt <= next_cnt;
         if (accept) debounced <= full_frame;
      end
   end

   // Events fire only from IDLE, so held keys never repeat and multi-presses need a full release.
   always_ff @(posedge clk) begin
      if (RST) begin
         state     <= IDLE;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (one_hot) begin
                  key_code  <= key_idx;
                  key_valid <= 1'b1;
                  state     <= HELD;
               end else if (debounced != 16'd0) begin
                  state <= LOCK;
               end
            end
            HELD, LOCK: begin
               if (debounced == 16'd0) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: frame-aligned vector table, hand-written corner sequences,
// then random key activity checked cycle by cycle against a frame-level reference model.
module tb_key_matrix_scan;

   localparam int SD = 4;
   localparam int DB = 3;
   localparam int FR = 4 * SD;

   logic       clk;
   logic       RST;
   logic [3:0] ROW;
   logic [3:0] COL;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;

   logic [15:0] keys;
   int checks;
   int failures;

   // Reference model state: frames, run length of identical frames, press bookkeeping.
   int          m_n;
   logic [15:0] m_frame;
   logic [15:0] m_prev;
   int          m_run;
   bit          m_pend;
   logic [15:0] m_pat;
   bit          m_clear;
   logic        m_down;
   logic        m_valid;
   logic [3:0]  m_code;

   typedef struct {
      logic [15:0] pattern;
      int          frames;
      int          exp_pulses;
      int          exp_step;
      logic [3:0]  exp_code;
      logic        exp_down;
   } vec_t;

   vec_t vecs[17];

   key_matrix_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
      .clk(clk),
      .RST(RST),
      .ROW(ROW),
      .COL(COL),
      .key_code(key_code),
      .key_valid(key_valid),
      .key_down(key_down)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Board model: a closed key pulls its column low while its row is driven.
   always_comb begin
      COL = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (ROW[r] == 1'b0) COL = COL & ~keys[4*r +: 4];
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelStep(input logic rst_v);
      int r;
      if (rst_v) begin
         m_n = 0; m_frame = 16'd0; m_prev = 16'd0; m_run = 0;
         m_pend = 0; m_pat = 16'd0; m_clear = 0;
         m_down = 1'b0; m_valid = 1'b0; m_code = 4'd0;
         return;
      end
      m_valid = 1'b0;
      if (m_pend) begin
         m_pend = 0;
         if (m_pat == 16'd0) begin
            m_clear = 0;
            m_down  = 1'b0;
         end else if (!m_clear) begin
            m_clear = 1;
            if ($countones(m_pat) == 1) begin
               m_valid = 1'b1;
               m_down  = 1'b1;
               for (int k = 0; k < 16; k++) if (m_pat[k]) m_code = 4'(k);
            end else begin
               m_down = 1'b0;
            end
         end
      end
      if ((m_n % SD) == SD - 1) begin
         r = (m_n / SD) % 4;
         m_frame[4*r +: 4] = keys[4*r +: 4];
         if (r == 3) begin
            if (m_frame == m_prev) m_run++;
            else m_run = 1;
            m_prev = m_frame;
            if (m_run == DB) begin
               m_pend = 1;
               m_pat  = m_frame;
            end
         end
      end
      m_n++;
   endtask

   task automatic stepCycle(input logic rst_v);
      logic [3:0] er;
      @(negedge clk);
      RST = rst_v;
      @(posedge clk);
      modelStep(rst_v);
      #1;
      er = 4'hF;
      er[(m_n / SD) % 4] = 1'b0;
      checkOutput("row", 16'(ROW), 16'(er));
      checkOutput("key_valid", 16'(key_valid), 16'(m_valid));
      checkOutput("key_code", 16'(key_code), 16'(m_code));
      checkOutput("key_down", 16'(key_down), 16'(m_down));
   endtask

   task automatic applyStimulus(input logic [15:0] k, input int ncyc, output int pulses,
                                output int first_step);
      keys = k;
      pulses = 0;
      first_step = 0;
      for (int s = 1; s <= ncyc; s++) begin
         stepCycle(1'b0);
         if (key_valid === 1'b1) begin
            pulses++;
            if (first_step == 0) first_step = s;
         end
      end
   endtask

   initial begin
      int pulses;
      int step;
      int kind;
      int dur;
      logic [3:0] row_seq [4];
      logic [15:0] pat;

      checks = 0;
      failures = 0;
      keys = 16'd0;
      RST = 1'b1;
      row_seq[0] = 4'b1110; row_seq[1] = 4'b1101; row_seq[2] = 4'b1011; row_seq[3] = 4'b0111;

      vecs[0]  = '{16'h0000, 4, 0, 0,  4'h0, 1'b0};
      vecs[1]  = '{16'h0200, 5, 1, 49, 4'h9, 1'b1};
      vecs[2]  = '{16'h0200, 4, 0, 0,  4'h9, 1'b1};
      vecs[3]  = '{16'h0000, 4, 0, 0,  4'h9, 1'b0};
      vecs[4]  = '{16'h0008, 1, 0, 0,  4'h9, 1'b0};
      vecs[5]  = '{16'h0000, 1, 0, 0,  4'h9, 1'b0};
      vecs[6]  = '{16'h0008, 4, 1, 49, 4'h3, 1'b1};
      vecs[7]  = '{16'h0000, 4, 0, 0,  4'h3, 1'b0};
      vecs[8]  = '{16'h8010, 4, 0, 0,  4'h3, 1'b0};
      vecs[9]  = '{16'h0010, 4, 0, 0,  4'h3, 1'b0};
      vecs[10] = '{16'h0000, 4, 0, 0,  4'h3, 1'b0};
      vecs[11] = '{16'h0010, 4, 1, 49, 4'h4, 1'b1};
      vecs[12] = '{16'h0000, 4, 0, 0,  4'h4, 1'b0};
      vecs[13] = '{16'h0020, 4, 1, 49, 4'h5, 1'b1};
      vecs[14] = '{16'h0420, 4, 0, 0,  4'h5, 1'b1};
      vecs[15] = '{16'h0400, 4, 0, 0,  4'h5, 1'b1};
      vecs[16] = '{16'h0000, 4, 0, 0,  4'h5, 1'b0};

      stepCycle(1'b1);
      checkOutput("reset row", 16'(ROW), 16'h000E);
      checkOutput("reset valid", 16'(key_valid), 16'h0);
      checkOutput("reset down", 16'(key_down), 16'h0);
      checkOutput("reset code", 16'(key_code), 16'h0);

      for (int i = 0; i < FR; i++) begin
         stepCycle(1'b0);
         checkOutput($sformatf("idle row step %0d", i + 1), 16'(ROW),
                     16'(row_seq[((i + 1) / SD) % 4]));
         checkOutput("idle valid", 16'(key_valid), 16'h0);
      end

      for (int v = 0; v < 17; v++) begin
         applyStimulus(vecs[v].pattern, vecs[v].frames * FR, pulses, step);
         checkOutput($sformatf("vec%0d pulses", v), 16'(pulses), 16'(vecs[v].exp_pulses));
         if (vecs[v].exp_step != 0)
            checkOutput($sformatf("vec%0d strobe step", v), 16'(step), 16'(vecs[v].exp_step));
         checkOutput($sformatf("vec%0d code", v), 16'(key_code), 16'(vecs[v].exp_code));
         checkOutput($sformatf("vec%0d down", v), 16'(key_down), 16'(vecs[v].exp_down));
      end

      // Reset while key 9 is held, landing mid-way through row 2's slot.
      applyStimulus(16'h0200, 4 * FR, pulses, step);
      checkOutput("pre-reset pulses", 16'(pulses), 16'd1);
      applyStimulus(16'h0200, FR + 2 * SD + 1, pulses, step);
      checkOutput("pre-reset row", 16'(ROW), 16'h000B);
      stepCycle(1'b1);
      checkOutput("mid reset row", 16'(ROW), 16'h000E);
      checkOutput("mid reset valid", 16'(key_valid), 16'h0);
      checkOutput("mid reset down", 16'(key_down), 16'h0);
      checkOutput("mid reset code", 16'(key_code), 16'h0);
      applyStimulus(16'h0200, 4 * FR, pulses, step);
      checkOutput("re-report pulses", 16'(pulses), 16'd1);
      checkOutput("re-report step", 16'(step), 16'd49);
      checkOutput("re-report code", 16'(key_code), 16'h9);
      checkOutput("re-report down", 16'(key_down), 16'h1);

      // Random key activity with unaligned durations and occasional resets.
      for (int seg = 0; seg < 250; seg++) begin
         kind = $urandom_range(0, 19);
         dur  = $urandom_range(8, 70);
         if (kind < 7) begin
            pat = 16'd0;
         end else if (kind < 15) begin
            pat = 16'd1 << $urandom_range(0, 15);
         end else if (kind < 19) begin
            pat = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
         end else begin
            pat = keys;
            stepCycle(1'b1);
         end
         applyStimulus(pat, dur, pulses, step);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
